// File: rtl/mmio_btn_irq_pkg.sv
// Shared constants for the memory-mapped button interrupt controller:
// register offsets, register index encoding and the default debounce length.
package mmio_btn_irq_pkg;

    localparam logic [31:0] STATE_OFS = 32'h0;
    localparam logic [31:0] PEND_OFS  = 32'h4;
    localparam logic [31:0] MASK_OFS  = 32'h8;
    localparam logic [31:0] EDGE_OFS  = 32'hC;

    typedef enum logic [1:0] {
        REG_STATE = 2'd0,
        REG_PEND  = 2'd1,
        REG_MASK  = 2'd2,
        REG_EDGE  = 2'd3
    } reg_idx_e;

    localparam int unsigned DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/mmio_btn_irq_ctrl_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debounce and
// single-cycle rise/fall strobes aligned with the STATE update edge.
module btn_debounce_ch #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          toggle;

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        toggle  = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
                toggle  = 1'b1;
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are combinational so PENDING captures on the same edge STATE moves.
    assign state_o = state_q;
    assign rise_o  = toggle & ~state_q;
    assign fall_o  = toggle &  state_q;

endmodule

// File: rtl/mmio_btn_irq_ctrl.sv
// Button interrupt controller: NUM_CH debounced inputs, STATE/PENDING/MASK/EDGE_SEL
// registers on the IOBUS and an INTR line (pulse mode with BTN_INTR_PULSE_EN).
module mmio_btn_irq_ctrl
    import mmio_btn_irq_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter logic [31:0] BASE_AD   = 32'h11000060
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] BTN_IN,
    input  logic [31:0]       IOBUS_ADDR,
    input  logic [31:0]       IOBUS_OUT,
    input  logic              IOBUS_WR,
    output logic [31:0]       RD_DATA,
    output logic              RD_HIT,
    output logic              INTR
);

    logic [NUM_CH-1:0] state, rise, fall, evt, active;
    logic [NUM_CH-1:0] pend_q, pend_d, mask_q, edge_q;
    logic [NUM_CH-1:0] wdata;
    logic [31:0]       ofs;
    reg_idx_e          idx;
    logic              wr_en;
    logic              intr_q, intr_d;
    logic              unused_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk_i   (CLK),
            .rst_ni  (RST_N),
            .btn_i   (BTN_IN[i]),
            .state_o (state[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    assign ofs       = IOBUS_ADDR - BASE_AD;
    assign RD_HIT    = (ofs == STATE_OFS) || (ofs == PEND_OFS) ||
                       (ofs == MASK_OFS)  || (ofs == EDGE_OFS);
    assign idx       = reg_idx_e'(ofs[3:2]);
    assign wr_en     = IOBUS_WR & RD_HIT;
    assign wdata     = IOBUS_OUT[NUM_CH-1:0];
    assign unused_ok = ^IOBUS_OUT;

    assign evt    = (rise & ~edge_q) | (fall & edge_q);
    assign active = pend_q & mask_q;

    always_comb begin
        RD_DATA = '0;
        if (RD_HIT) begin
            case (idx)
                REG_STATE: RD_DATA[NUM_CH-1:0] = state;
                REG_PEND:  RD_DATA[NUM_CH-1:0] = pend_q;
                REG_MASK:  RD_DATA[NUM_CH-1:0] = mask_q;
                REG_EDGE:  RD_DATA[NUM_CH-1:0] = edge_q;
                default:   RD_DATA = '0;
            endcase
        end
    end

    // Clear is applied before the set so a same-cycle event keeps PENDING high.
    always_comb begin
        pend_d = pend_q;
        if (wr_en && idx == REG_PEND) pend_d = pend_q & ~wdata;
        pend_d = pend_d | evt;
    end

`ifdef BTN_INTR_PULSE_EN
    logic [NUM_CH-1:0] active_q;
    assign intr_d = |(active & ~active_q);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) active_q <= '0;
        else        active_q <= active;
    end
`else
    assign intr_d = |active;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            intr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            intr_q <= intr_d;
            if (wr_en && idx == REG_MASK) mask_q <= wdata;
            if (wr_en && idx == REG_EDGE) edge_q <= wdata;
        end
    end

    assign INTR = intr_q;

endmodule
